// File: rtl/score_keeper.sv
// Four-digit hex score keeper with debounced push buttons; `SCORE_DEC_EN adds a dec input that turns presses into decrements.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles from a clean raw edge to num; no backpressure (buttons are free-running).
module score_keeper #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
`ifdef SCORE_DEC_EN
  input  logic        dec,
`endif
  output logic [15:0] num,
  output logic        changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_press;
  logic [3:0] w_step;

`ifdef SCORE_DEC_EN
  assign w_step = dec ? 4'hF : 4'h1;
`else
  assign w_step = 4'h1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_deb;
    logic          r_press;
    logic          w_diff;
    logic          w_hit;

    assign w_diff      = r_sync2[gi] ^ r_deb;
    assign w_hit       = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_press[gi] = r_press;

    // Only a qualified 0->1 toggle of the debounced level is a press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_deb   <= 1'b0;
        r_press <= 1'b0;
      end else begin
        r_press <= w_diff & w_hit & ~r_deb;
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_hit) begin
          r_cnt <= '0;
          r_deb <= ~r_deb;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // Each digit wraps on its own; there is no carry between digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num     <= '0;
      changed <= 1'b0;
    end else begin
      changed <= |w_press;
      for (int i = 0; i < 4; i++) begin
        if (w_press[i]) num[4*i +: 4] <= num[4*i +: 4] + w_step;
      end
    end
  end

endmodule
